// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_D  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-over-fetch priority select for the memory arbiter.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN:
// after STARVE_LIMIT data grants taken while IF waits, IF wins once.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req_valid,
    input  logic       d_req_valid,
    input  logic       mem_req_ready,
    input  logic       arb_idle,
    output arb_owner_t win,
    output logic       win_vld
);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             accept;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT)) && if_req_valid;
    assign accept     = arb_idle && mem_req_ready && win_vld;

    // Count data grants taken while IF is waiting; any IF grant clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (win == OWN_IF) begin
                starve_cnt <= '0;
            end else if (if_req_valid && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    logic starve_hit;
    logic unused_guard_inputs;

    // Strict data priority: the guard never fires and its inputs go unread.
    assign starve_hit          = 1'b0;
    assign unused_guard_inputs = &{1'b0, clk, rst, mem_req_ready, arb_idle, (STARVE_LIMIT > 0)};
`endif

    // Data wins unless the starvation guard hands this slot to IF.
    always_comb begin
        win_vld = d_req_valid || if_req_valid;
        win     = OWN_IF;
        if (d_req_valid && !starve_hit) begin
            win = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and the data stage.
// One transaction outstanding at a time; responses are registered back to
// the requester that issued them. Optional starvation guard: define
// MEM_ARB_STARVE_GUARD_EN (implemented in mem_arb_prio).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wd,
    input  logic              d_we,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_t state_q, state_d;
    arb_owner_t win;
    logic       win_vld;
    logic       d_wr_p0;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .d_req_valid   (d_req_valid),
        .mem_req_ready (mem_req_ready),
        .arb_idle      (state_q == IDLE),
        .win           (win),
        .win_vld       (win_vld)
    );

    // Request payload follows the current winner; only qualified by mem_req_valid.
    assign mem_addr = (win == OWN_D) ? d_addr : if_addr;
    assign mem_wd   = (win == OWN_D) ? d_wd   : '0;
    assign mem_we   = (win == OWN_D) ? d_we   : 1'b0;

    // State register; an in-flight transaction is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, memory request and requester readies.
    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req_valid = win_vld && rst;
                if (win_vld && rst) begin
                    if (win == OWN_D) begin
                        d_req_ready = mem_req_ready;
                    end else begin
                        if_req_ready = mem_req_ready;
                    end
                    if (mem_req_ready) begin
                        state_d = (win == OWN_D) ? WAIT_D : WAIT_IF;
                    end
                end
            end
            WAIT_IF, WAIT_D: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Remember whether the accepted data transaction was a write.
    always_ff @(posedge clk) begin
        if (d_req_valid && d_req_ready) begin
            d_wr_p0 <= d_we;
        end
    end

    // Registered response path: one-cycle pulse to the owner of the transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_data   <= '0;
        end else begin
            if_rsp_valid <= (state_q == WAIT_IF) && mem_rvalid;
            d_rsp_valid  <= (state_q == WAIT_D) && mem_rvalid;
            if ((state_q == WAIT_IF) && mem_rvalid) begin
                if_rsp_data <= mem_rd;
            end
            if ((state_q == WAIT_D) && mem_rvalid) begin
                d_rsp_data <= d_wr_p0 ? '0 : mem_rd;
            end
        end
    end

endmodule
